larpix_packet_rx: RTL and testbench

Host-side UART packet receiver for the LArPix serial link: the receiving end of the chip's `piso` transmit line. It oversamples one serial line, reassembles each WIDTH-bit frame and checks odd parity. The 63-bit packet is then handed downstream through a one-entry valid/ready output register. It sits in the FPGA/MCP model opposite `external_interface`, feeding packet parsing and scoreboarding.

---
 rtl/larpix_packet_rx.sv | 132 +++++++++++++
 tb/tb_larpix_packet_rx.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/larpix_packet_rx.sv
// LArPix host-side UART receiver: oversampled, odd-parity, one-entry output.
// Optional parity checking is enabled with `define RX_PARITY_CHECK_EN.
module larpix_packet_rx #(
  parameter int WIDTH      = 64,
  parameter int OVERSAMPLE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_in,
  output logic [WIDTH-2:0] rx_data,
  output logic [1:0]       rx_packet_type,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             parity_error,
  output logic             framing_error,
  output logic             overrun,
  output logic             busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] HALF  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BLAST = BW'(WIDTH - 1);

`ifdef RX_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t state, state_nx;

  logic             sync1, rx_s, rx_d;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [BW-1:0]    bit_cnt, bit_nx;
  logic [WIDTH-1:0] sh, sh_nx;
  logic             frame_done, stop_bad;
  logic             par_bad, good;

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt + 1'b1;
    bit_nx     = bit_cnt;
    sh_nx      = sh;
    frame_done = 1'b0;
    stop_bad   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (rx_d && !rx_s) state_nx = START;
      end
      START: begin
        if (cnt == HALF) begin
          cnt_nx   = '0;
          bit_nx   = '0;
          state_nx = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_nx = '0;
          sh_nx  = {rx_s, sh[WIDTH-1:1]};
          bit_nx = bit_cnt + 1'b1;
          if (bit_cnt == BLAST) state_nx = STOP;
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_nx     = '0;
          state_nx   = IDLE;
          frame_done = 1'b1;
          stop_bad   = !rx_s;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Odd parity: a good frame XORs to 1 across all WIDTH bits.
  assign par_bad = PAR_EN && frame_done && !stop_bad && !(^sh);
  assign good    = frame_done && !stop_bad && !par_bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1         <= 1'b1;
      rx_s          <= 1'b1;
      rx_d          <= 1'b1;
      state         <= IDLE;
      cnt           <= '0;
      bit_cnt       <= '0;
      sh            <= '0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      sync1         <= rx_in;
      rx_s          <= sync1;
      rx_d          <= rx_s;
      state         <= state_nx;
      cnt           <= cnt_nx;
      bit_cnt       <= bit_nx;
      sh            <= sh_nx;
      parity_error  <= par_bad;
      framing_error <= frame_done && stop_bad;
      // A load in the same cycle as a transfer keeps rx_valid high.
      if (good) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= sh[WIDTH-2:0];
          rx_valid <= 1'b1;
        end else begin
          overrun  <= 1'b1;
        end
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign rx_packet_type = rx_data[1:0];
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_larpix_packet_rx.sv
// Directed self-checking bench for larpix_packet_rx.
// Builds with or without RX_PARITY_CHECK_EN.
module tb_larpix_packet_rx;

  localparam int W   = 64;
  localparam int OS  = 4;
  localparam int LAT = 2 + OS / 2 + (W + 1) * OS + 1;

  localparam logic [62:0] P1 = 63'h4000_0000_0064_000C;
  localparam logic [62:0] PA = 63'h0123_4567_89AB_CDEF;
  localparam logic [62:0] PB = 63'h5555_0000_AAAA_0003;
  localparam logic [62:0] PF = 63'h7FFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_in = 1'b1;
  logic        rx_ready = 1'b0;
  logic [62:0] rx_data;
  logic [1:0]  rx_packet_type;
  logic        rx_valid, parity_error, framing_error, overrun, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fall_cyc = 0;
  int rise_cyc = 0;
  int n_valid  = 0;
  int n_pe     = 0;
  int n_fe     = 0;
  int n_xfer   = 0;
  logic v_prev = 1'b0;

  larpix_packet_rx #(.WIDTH(W), .OVERSAMPLE(OS)) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_in         (rx_in),
    .rx_data       (rx_data),
    .rx_packet_type(rx_packet_type),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .overrun       (overrun),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid && !v_prev) begin
      n_valid++;
      rise_cyc = cyc;
    end
    v_prev = rx_valid;
    if (parity_error) n_pe++;
    if (framing_error) n_fe++;
    if (rx_valid && rx_ready) n_xfer++;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    rx_in = b;
    step(OS);
  endtask

  task automatic send_frame(input logic [62:0] d, input logic par,
                            input logic stop);
    fall_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 63; i++) drive_bit(d[i]);
    drive_bit(par);
    drive_bit(stop);
    rx_in = 1'b1;
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_in = 1'b1;
    rx_ready = 1'b0;
    step(3);
    n_checks++;
    if ({rx_valid, overrun, busy, parity_error, framing_error} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 00000",
               {rx_valid, overrun, busy, parity_error, framing_error});
    end
    n_checks++;
    if (rx_data !== 63'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h required 0", rx_data);
    end
    reset = 1'b0;
    step(20);
    n_checks++;
    if (busy !== 1'b0 || n_valid !== 0) begin
      n_fail++;
      $display("FAIL idle_line: busy %b valid_count %0d required 0 0",
               busy, n_valid);
    end
  endtask

  task automatic test_basic();
    int v0, pe0, fe0;
    v0 = n_valid; pe0 = n_pe; fe0 = n_fe;
    send_frame(P1, ~^P1, 1'b1);
    step(4);
    n_checks++;
    if (n_valid - v0 !== 1) begin
      n_fail++;
      $display("FAIL basic_valid: got %0d frames required 1", n_valid - v0);
    end
    n_checks++;
    if (rise_cyc - fall_cyc !== LAT) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d required %0d",
               rise_cyc - fall_cyc, LAT);
    end
    n_checks++;
    if (rx_data !== P1) begin
      n_fail++;
      $display("FAIL basic_data: got %h required %h", rx_data, P1);
    end
    n_checks++;
    if (rx_packet_type !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_type: got %b required 00", rx_packet_type);
    end
    n_checks++;
    if (n_pe !== pe0 || n_fe !== fe0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_errors: pe %0d fe %0d ovr %b required 0 0 0",
               n_pe - pe0, n_fe - fe0, overrun);
    end
    consume();
    n_checks++;
    if (rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_consume: rx_valid %b required 0", rx_valid);
    end
  endtask

  task automatic test_parity();
    int v0, pe0;
    v0 = n_valid; pe0 = n_pe;
    send_frame(P1, ^P1, 1'b1);
    step(4);
`ifdef RX_PARITY_CHECK_EN
    n_checks++;
    if (n_pe - pe0 !== 1) begin
      n_fail++;
      $display("FAIL parity_pulse: got %0d high cycles required 1",
               n_pe - pe0);
    end
    n_checks++;
    if (rx_valid !== 1'b0 || n_valid !== v0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_drop: valid %b frames %0d ovr %b required 0 0 0",
               rx_valid, n_valid - v0, overrun);
    end
`else
    n_checks++;
    if (n_valid - v0 !== 1 || rx_data !== P1) begin
      n_fail++;
      $display("FAIL parity_deliver: frames %0d data %h required 1 %h",
               n_valid - v0, rx_data, P1);
    end
    n_checks++;
    if (n_pe !== pe0) begin
      n_fail++;
      $display("FAIL parity_tied: got %0d pulses required 0", n_pe - pe0);
    end
    consume();
`endif
  endtask

  task automatic test_framing();
    int v0, fe0;
    v0 = n_valid; fe0 = n_fe;
    send_frame(P1, ~^P1, 1'b0);
    step(4);
    n_checks++;
    if (n_fe - fe0 !== 1) begin
      n_fail++;
      $display("FAIL framing_pulse: got %0d high cycles required 1",
               n_fe - fe0);
    end
    n_checks++;
    if (rx_valid !== 1'b0 || n_valid !== v0) begin
      n_fail++;
      $display("FAIL framing_drop: valid %b frames %0d required 0 0",
               rx_valid, n_valid - v0);
    end
    send_frame(63'h1, 1'b0, 1'b1);
    step(4);
    n_checks++;
    if (rx_valid !== 1'b1 || rx_data !== 63'h1 || rx_packet_type !== 2'b01) begin
      n_fail++;
      $display("FAIL framing_next: valid %b data %h type %b required 1 1 01",
               rx_valid, rx_data, rx_packet_type);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int v0, x0;
    v0 = n_valid;
    rx_ready = 1'b0;
    send_frame(PA, ~^PA, 1'b1);
    send_frame(PB, ~^PB, 1'b1);
    step(3);
    n_checks++;
    if (rx_data !== PA || n_valid - v0 !== 1) begin
      n_fail++;
      $display("FAIL b2b_keep: data %h frames %0d required %h 1",
               rx_data, n_valid - v0, PA);
    end
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_overrun: got %b required 1", overrun);
    end
    step(10);
    x0 = n_xfer;
    rx_ready = 1'b1;
    step(3);
    rx_ready = 1'b0;
    step(1);
    n_checks++;
    if (n_xfer - x0 !== 1 || rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_xfer: transfers %0d valid %b required 1 0",
               n_xfer - x0, rx_valid);
    end
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_sticky: got %b required 1", overrun);
    end
  endtask

  task automatic test_glitch();
    int v0, pe0, fe0;
    v0 = n_valid; pe0 = n_pe; fe0 = n_fe;
    rx_in = 1'b0;
    step(OS / 2 - 1);
    rx_in = 1'b1;
    step(2);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_start: busy %b required 1", busy);
    end
    step(2);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_idle: busy %b required 0", busy);
    end
    step(10);
    n_checks++;
    if (n_valid !== v0 || n_pe !== pe0 || n_fe !== fe0) begin
      n_fail++;
      $display("FAIL glitch_quiet: frames %0d pe %0d fe %0d required 0 0 0",
               n_valid - v0, n_pe - pe0, n_fe - fe0);
    end
    rx_in = 1'b0;
    step(200);
    n_checks++;
    if (n_valid !== v0 || n_fe !== fe0 || rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stuck_low: frames %0d fe %0d valid %b required 0 0 0",
               n_valid - v0, n_fe - fe0, rx_valid);
    end
    rx_in = 1'b1;
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step(300);
    n_checks++;
    if (busy !== 1'b0 || overrun !== 1'b0 || n_valid !== v0 || n_fe !== fe0) begin
      n_fail++;
      $display("FAIL stuck_reset: busy %b ovr %b frames %0d fe %0d required 0",
               busy, overrun, n_valid - v0, n_fe - fe0);
    end
  endtask

  task automatic test_reset_midframe();
    int v0, pe0, fe0;
    v0 = n_valid; pe0 = n_pe; fe0 = n_fe;
    drive_bit(1'b0);
    for (int i = 0; i < 30; i++) drive_bit(P1[i]);
    rx_in = P1[30];
    step(2);
    reset = 1'b1;
    step(3);
    rx_in = 1'b1;
    step(1);
    reset = 1'b0;
    step(5);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_abort: busy %b required 0", busy);
    end
    send_frame(PF, ~^PF, 1'b1);
    step(4);
    n_checks++;
    if (n_valid - v0 !== 1 || rx_data !== PF) begin
      n_fail++;
      $display("FAIL midreset_data: frames %0d data %h required 1 %h",
               n_valid - v0, rx_data, PF);
    end
    n_checks++;
    if (rise_cyc - fall_cyc !== LAT) begin
      n_fail++;
      $display("FAIL midreset_latency: got %0d required %0d",
               rise_cyc - fall_cyc, LAT);
    end
    n_checks++;
    if (overrun !== 1'b0 || n_pe !== pe0 || n_fe !== fe0) begin
      n_fail++;
      $display("FAIL midreset_errors: ovr %b pe %0d fe %0d required 0 0 0",
               overrun, n_pe - pe0, n_fe - fe0);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_framing();
    test_back_to_back();
    test_glitch();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
